wb_master_arbiter: RTL
======================

# wb_master_arbiter

Round-robin arbiter sharing one Wishbone master command port (start/active handshake, `address`, `selection`, `write`, `data_wr`, `data_rd`) among up to eight requesters. Requesters include `daq_sm` instances, DSP engines and debug logic. The block latches one requester's command, sequences the start/active handshake on the shared master, and returns read data with a done pulse to the granted requester only. It sits between the requesters and the single `wb_master` instance in the DAQ/DSP subsystem.

## Interface
- `NREQ`, 4, number of requesters (2..8).
- `dw`, 32, data width.
- `aw`, 32, address width.
- `TIMEOUT`, 255, handshake watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`).

Ports:
- `wb_clk`  in  1  the single clock.
- `wb_rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  level request per requester; held high until its `done` bit.
- `req_address`  in  NREQ*aw  per-requester address; slice i is requester i.
- `req_selection`  in  NREQ*4  per-requester byte select.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_data_wr`  in  NREQ*dw  per-requester write data.
- `done`  out  NREQ  one-cycle pulse to the granted requester.
- `err`  out  NREQ  one-cycle pulse, coincident with `done`, on watchdog abort.
- `rd_data`  out  dw  read data; valid while `done` is high.
- `grant`  out  NREQ  one-hot; current owner, held IDLE→DONE.
- `address`, `selection`, `write`, `data_wr`, `start`  out  aw/4/1/dw/1  to the shared master.
- `data_rd`  in  dw  from the master; valid when `active` falls.
- `active`  in  1  master busy flag.

## Operation
- Reset values: `start`, `write`, `address`, `selection`, `data_wr`, `done`, `err`, `grant` and `rd_data` are all 0. State is IDLE and the priority pointer `last` is NREQ-1.
- IDLE: if any `req` bit is high, pick the first set bit searching `last`+1, `last`+2, … with wrap modulo NREQ.
  - Set `grant`.
  - Latch that requester's address/selection/write/data_wr onto the master outputs.
  - Go to ISSUE. `start` goes high in the same registered update.
- ISSUE: hold `start` = 1 and the command stable. When `active` = 1, clear `start` and go to WAIT.
- WAIT: when `active` = 0, register `data_rd` into `rd_data` (forced to 0 for writes) and go to DONE.
- DONE: pulse `done[g]` for one cycle, set `last` = g, clear `grant` and all command outputs, then return to IDLE.
- The command is latched at grant. Changes to the requester's inputs after grant are ignored.
- Simultaneous requests: the rotating pointer gives each active requester at most one transaction before any other requester gets a second.
- A requester that keeps `req` high after its `done` is treated as a new request. It competes at lowest priority.
- Dropping `req` mid-transaction does not abort it; `done` still pulses.
- Async reset mid-transaction: all outputs clear immediately and no `done` is issued. The requester must reissue after reset.

## Timing
- Request high at cycle N in IDLE → `grant` and `start` high at N+1.
- `active` sampled high at cycle M → `start` low at M+1.
- `active` sampled low at cycle K in WAIT → `rd_data` valid and `done` high at K+1 for exactly one cycle.
- IDLE is re-entered at K+2, which is also the earliest next grant decision. Minimum arbiter overhead is 3 cycles per transaction plus master latency.
- `grant` is never changed while the state is not IDLE.

## Configuration
- `ARB_TIMEOUT_EN` defined: an 8..16-bit counter clears on every state change and counts in ISSUE and WAIT.
  - When it reaches `TIMEOUT`, the block drops `start`, pulses `done[g]` and `err[g]` with `rd_data` = 0, advances `last`, and returns to IDLE.
  - The master is assumed reset externally after an abort.
- `ARB_TIMEOUT_EN` undefined: no counter is built, `err` is tied to 0, and the block waits indefinitely.

## Test plan
- Single read: `req[1]`=1 with `req_address[1]`=0x2000_0004, master returns 0xDEAD_BEEF after 3 cycles → `grant`=4'b0010, one `start` handshake, `done[1]` pulse with `rd_data`=0xDEAD_BEEF, `err`=0.
- Contention after reset: `req`=4'b1111 held → grants in order 0,1,2,3,0. Each `done` arrives before the next `grant`, and no requester gets two in a row.
- Write: `req[2]` write of 0x1234_5678 with selection 4'h3 → `write`=1, `data_wr`=0x1234_5678, `selection`=4'h3 stable from `start` until `active` falls; `done[2]` pulses with `rd_data`=0.
- Input change after grant: change `req_address[0]` during WAIT → `address` keeps the originally latched value.
- Reset mid-WAIT: deassert `wb_rst_n` while `active`=1 → all outputs 0 immediately, no `done`; after release, `req[0]` is granted first.
- `ARB_TIMEOUT_EN` with `TIMEOUT`=16 and `active` stuck 0 → `done[3]` and `err[3]` pulse 16 cycles after ISSUE entry; without the macro, the block is still in ISSUE after 1000 cycles.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter multiplexing up to eight requesters onto one Wishbone master command port.
// Optional handshake watchdog: define ARB_TIMEOUT_EN to build the abort counter and err pulses.
module wb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk,
  input  logic               wb_rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*aw-1:0] req_address,
  input  logic [NREQ*4-1:0]  req_selection,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*dw-1:0] req_data_wr,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [dw-1:0]      rd_data,
  output logic [NREQ-1:0]    grant,
  output logic [aw-1:0]      address,
  output logic [3:0]         selection,
  output logic               write,
  output logic [dw-1:0]      data_wr,
  output logic               start,
  input  logic [dw-1:0]      data_rd,
  input  logic               active
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("wb_master_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Returns {found, index}: first set request after 'last', wrapping modulo NREQ.
  function automatic logic [LW:0] rr_pick(input logic [NREQ-1:0] r, input logic [LW-1:0] last);
    logic [LW:0] res;
    int          idx;
    res = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!res[LW] && r[idx[LW-1:0]]) begin
        res = {1'b1, idx[LW-1:0]};
      end
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [LW-1:0]   sel_q, sel_d;
  logic [LW-1:0]   last_q, last_d;
  logic [aw-1:0]   address_q, address_d;
  logic [3:0]      selection_q, selection_d;
  logic            write_q, write_d;
  logic [dw-1:0]   data_wr_q, data_wr_d;
  logic            start_q, start_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [dw-1:0]   rd_data_q, rd_data_d;
  logic [LW:0]     pick;
  int              pi;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]     tmo_q, tmo_d;
  logic [NREQ-1:0] err_q, err_d;
  logic            tmo_hit;
`endif

  // Next-state and output computation for the grant/handshake sequencer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    address_d   = address_q;
    selection_d = selection_q;
    write_d     = write_q;
    data_wr_d   = data_wr_q;
    start_d     = start_q;
    done_d      = '0;
    rd_data_d   = rd_data_q;
    pick        = rr_pick(req, last_q);
    pi          = int'(pick[LW-1:0]);
    case (state_q)
      S_IDLE: begin
        if (pick[LW]) begin
          state_d     = S_ISSUE;
          grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick[LW-1:0];
          sel_d       = pick[LW-1:0];
          address_d   = req_address[pi*aw +: aw];
          selection_d = req_selection[pi*4 +: 4];
          write_d     = req_write[pi];
          data_wr_d   = req_data_wr[pi*dw +: dw];
          start_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (active) begin
          start_d = 1'b0;
          state_d = S_WAIT;
        end else begin
          start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!active) begin
          rd_data_d = write_q ? '0 : data_rd;
          done_d    = grant_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        last_d      = sel_q;
        grant_d     = '0;
        address_d   = '0;
        selection_d = 4'h0;
        write_d     = 1'b0;
        data_wr_d   = '0;
        start_d     = 1'b0;
        rd_data_d   = '0;
        state_d     = S_IDLE;
      end
      default: begin
        grant_d = '0;
        start_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    // Watchdog abort overrides a normal completion landing on the same cycle.
    err_d   = '0;
    tmo_hit = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && ((tmo_q + 16'd1) == 16'(TIMEOUT));
    if (tmo_hit) begin
      start_d   = 1'b0;
      done_d    = grant_q;
      err_d     = grant_q;
      rd_data_d = '0;
      state_d   = S_DONE;
    end else begin
      err_d = '0;
    end
    if (state_d != state_q) begin
      tmo_d = 16'd0;
    end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = 16'd0;
    end
`endif
  end

  // State and registered-output flops.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= LW'(NREQ - 1);
      address_q   <= '0;
      selection_q <= 4'h0;
      write_q     <= 1'b0;
      data_wr_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= '0;
      rd_data_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= 16'd0;
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      address_q   <= address_d;
      selection_q <= selection_d;
      write_q     <= write_d;
      data_wr_q   <= data_wr_d;
      start_q     <= start_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign address   = address_q;
  assign selection = selection_q;
  assign write     = write_q;
  assign data_wr   = data_wr_q;
  assign start     = start_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
`ifdef ARB_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = '0;
`endif

endmodule
